// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave fronting a word-addressed local memory with byte/halfword/word write lanes.
// Latency: data phase of WAIT_STATES+1 cycles for OKAY transfers, fixed 2 cycles for ERROR.
// Backpressure: drives hreadyout low during wait states and ERR1; ignores the bus while hready is low.
module ahb_slave_mem #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [15:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [11:0] idx_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;
    logic        write_q;

    logic [31:0] mem [DEPTH];

    logic [11:0] a_idx;
    logic        accept;
    logic        a_err;
    logic        commit;
    logic [3:0]  be_q;
    logic [31:0] wr_word;
    logic [31:0] rd_new;
    logic        unused_hi;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0:    return 4'b0001 << off;
            3'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Upper address bits are consumed by the decoder; only the word index matters here.
    assign unused_hi = ^haddr[15:14];
    assign a_idx     = haddr[13:2];

    // hreadyout gates acceptance so a stray hready during our own stall cannot start a transfer.
    assign accept = hsel & hready & htrans[1] & hreadyout;

    assign a_err = (32'(a_idx) >= 32'(DEPTH))
                 | (hsize > 3'd2)
                 | ((hsize == 3'd1) & haddr[0])
                 | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

    assign commit = (state == ST_DATA) & write_q;
    assign be_q   = lane_mask(size_q, off_q);

    always_comb begin
        wr_word = mem[idx_q[AW-1:0]];
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                wr_word[8*b +: 8] = hwdata[8*b +: 8];
            end
        end
    end

    // A zero-wait read accepted on the commit edge of a write to the same word sees the merged value.
    assign rd_new = (commit && (idx_q == a_idx)) ? wr_word : mem[a_idx[AW-1:0]];

    always_ff @(posedge hclk) begin
        if (commit) begin
            mem[idx_q[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            idx_q     <= 12'd0;
            off_q     <= 2'd0;
            size_q    <= 3'd0;
            write_q   <= 1'b0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        state     <= ST_DATA;
                        wait_cnt  <= 4'd0;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                        hrdata    <= write_q ? 32'd0 : mem[idx_q[AW-1:0]];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                    hrdata    <= 32'd0;
                end
                default: begin
                    if (accept) begin
                        idx_q   <= a_idx;
                        off_q   <= haddr[1:0];
                        size_q  <= hsize;
                        write_q <= hwrite;
                        if (a_err) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                            hrdata    <= 32'd0;
                        end else if (WAIT_STATES > 0) begin
                            state     <= ST_WAIT;
                            wait_cnt  <= 4'(WAIT_STATES);
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                            hrdata    <= 32'd0;
                        end else begin
                            state     <= ST_DATA;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                            hrdata    <= hwrite ? 32'd0 : rd_new;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                        hrdata    <= 32'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a three-wait instance share one AHB-Lite bus.
// Driver queues each accepted transfer's expected response; a negedge monitor checks the data phase.
module tb_ahb_slave_mem;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel_drv;
    int          tgt;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] rd0, rd1;
    logic        ho0, ho1, hr0, hr1;
    int          dsel = 0;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    logic        m_ho, m_hr;
    logic [31:0] m_rd;

    always #5 hclk = ~hclk;

    assign hready = (dsel == 1) ? ho1 : ho0;

    always @(posedge hclk) begin
        if (hready) dsel <= tgt;
    end

    ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_drv && tgt == 0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(rd0), .hreadyout(ho0), .hresp(hr0)
    );

    ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_drv && tgt == 1), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hrdata(rd1), .hreadyout(ho1), .hresp(hr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge hclk) begin
        if (hresetn === 1'b1) begin
            m_ho = (dsel == 1) ? ho1 : ho0;
            m_hr = (dsel == 1) ? hr1 : hr0;
            m_rd = (dsel == 1) ? rd1 : rd0;
            if (q.size() == 0) begin
                chk("idle_ctl", {30'd0, m_ho, m_hr}, 32'h2);
                chk("idle_rdata", m_rd, 32'd0);
            end else if (!m_ho) begin
                chk("stall_resp", {31'd0, m_hr}, {31'd0, q[0].err});
                chk("stall_rdata", m_rd, 32'd0);
                stall_cnt++;
            end else begin
                chk("resp", {31'd0, m_hr}, {31'd0, q[0].err});
                chk("stalls", stall_cnt, q[0].err ? 1 : ((q[0].t == 1) ? 3 : 0));
                chk("rdata", m_rd, (q[0].rd && !q[0].err) ? q[0].data : 32'd0);
                void'(q.pop_front());
                stall_cnt = 0;
            end
        end
    end

    task automatic xfer(input int t, input bit wr, input logic [15:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input bit err, input logic [31:0] rdx);
        exp_t e;
        int   n;
        tgt      = t;
        hsel_drv = 1'b1;
        haddr    = a;
        htrans   = 2'd2;
        hwrite   = wr;
        hsize    = sz;
        n = 0;
        while (!hready && n < 50) begin
            @(posedge hclk);
            #1;
            n++;
        end
        if (!hready) chk("hready_timeout", {31'd0, hready}, 32'd1);
        @(posedge hclk);
        e.err  = err;
        e.rd   = !wr;
        e.data = rdx;
        e.t    = t;
        q.push_back(e);
        #1;
        hwdata = wr ? wd : 32'h0BAD0BAD;
    endtask

    task automatic drain();
        int n;
        hsel_drv = 1'b0;
        htrans   = 2'd0;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge hclk);
            #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    endtask

    task automatic idle_sel(input logic [1:0] tr);
        tgt      = 0;
        hsel_drv = 1'b1;
        htrans   = tr;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hresetn  = 1'b0;
        hsel_drv = 1'b0;
        tgt      = 0;
        haddr    = 16'd0;
        htrans   = 2'd0;
        hwrite   = 1'b0;
        hsize    = 3'd0;
        hwdata   = 32'd0;
        repeat (3) @(posedge hclk);
        #1;
        chk("reset_ws0_ctl", {30'd0, ho0, hr0}, 32'h2);
        chk("reset_ws0_rdata", rd0, 32'd0);
        chk("reset_ws3_ctl", {30'd0, ho1, hr1}, 32'h2);
        chk("reset_ws3_rdata", rd1, 32'd0);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // zero-wait word write/read and byte-lane merging
        xfer(0, 1, 16'h0008, 3'd2, 32'hDEADBEEF, 0, 32'd0);
        xfer(0, 0, 16'h0008, 3'd2, 32'd0, 0, 32'hDEADBEEF);
        xfer(0, 1, 16'h0040, 3'd2, 32'h11223344, 0, 32'd0);
        xfer(0, 1, 16'h0041, 3'd0, 32'h0000AA00, 0, 32'd0);
        xfer(0, 1, 16'h0042, 3'd1, 32'hBBCC0000, 0, 32'd0);
        xfer(0, 0, 16'h0040, 3'd2, 32'd0, 0, 32'hBBCCAA44);
        drain();

        // back-to-back read-after-write, then IDLE/BUSY with select
        xfer(0, 1, 16'h0020, 3'd2, 32'h00000055, 0, 32'd0);
        xfer(0, 0, 16'h0020, 3'd2, 32'd0, 0, 32'h00000055);
        idle_sel(2'd0);
        idle_sel(2'd1);
        xfer(0, 0, 16'h0020, 3'd2, 32'd0, 0, 32'h00000055);
        drain();

        // error responses leave memory untouched
        xfer(0, 1, 16'h0010, 3'd2, 32'h01020304, 0, 32'd0);
        xfer(0, 0, 16'h0400, 3'd2, 32'd0, 1, 32'd0);
        xfer(0, 1, 16'h0012, 3'd2, 32'hFFFFFFFF, 1, 32'd0);
        xfer(0, 1, 16'h0011, 3'd1, 32'hEEEEEEEE, 1, 32'd0);
        xfer(0, 0, 16'h0010, 3'd3, 32'd0, 1, 32'd0);
        xfer(0, 0, 16'h0010, 3'd2, 32'd0, 0, 32'h01020304);
        xfer(0, 1, 16'h03FC, 3'd2, 32'h0F0E0D0C, 0, 32'd0);
        xfer(0, 0, 16'h03FC, 3'd2, 32'd0, 0, 32'h0F0E0D0C);
        xfer(0, 0, 16'h03FD, 3'd0, 32'd0, 0, 32'h0F0E0D0C);
        xfer(0, 0, 16'hC3FC, 3'd2, 32'd0, 0, 32'h0F0E0D0C);
        drain();

        // three wait states
        xfer(1, 1, 16'h0010, 3'd2, 32'hA5A50001, 0, 32'd0);
        xfer(1, 0, 16'h0010, 3'd2, 32'd0, 0, 32'hA5A50001);
        xfer(1, 0, 16'h0013, 3'd3, 32'd0, 1, 32'd0);
        xfer(1, 1, 16'h0030, 3'd2, 32'h12345678, 0, 32'd0);
        xfer(1, 0, 16'h0030, 3'd2, 32'd0, 0, 32'h12345678);
        drain();

        // reset asserted in the second wait cycle of a write
        tgt      = 1;
        hsel_drv = 1'b1;
        haddr    = 16'h0030;
        htrans   = 2'd2;
        hwrite   = 1'b1;
        hsize    = 3'd2;
        @(posedge hclk);
        q.push_back('{err: 1'b0, rd: 1'b0, data: 32'd0, t: 1});
        #1;
        hsel_drv = 1'b0;
        htrans   = 2'd0;
        hwdata   = 32'hCAFE0000;
        @(posedge hclk);
        #3;
        hresetn   = 1'b0;
        q.delete();
        stall_cnt = 0;
        #1;
        chk("async_rst_ctl", {30'd0, ho1, hr1}, 32'h2);
        chk("async_rst_rdata", rd1, 32'd0);
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        xfer(1, 0, 16'h0030, 3'd2, 32'd0, 0, 32'h12345678);
        drain();
        xfer(0, 0, 16'h0010, 3'd2, 32'd0, 0, 32'h01020304);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite slave holding a word-addressed local memory, sitting directly downstream of the address decoder and consuming one of its `hsel_n` outputs. It executes read and write transfers with a configurable number of wait states. It returns OKAY, or a two-cycle ERROR response for out-of-range, misaligned or unsupported transfers. Three instances (one per decoder select) form the slave side of the bus.

## Interface

- `DEPTH`, 256: memory size in 32-bit words, 1..4096.
- `WAIT_STATES`, 0: wait cycles inserted in every OKAY data phase, 0..15.

- `hclk`  in  1  bus clock, all state updates on rising edge.
- `hresetn`  in  1  reset; one clock; asynchronous, active-low.
- `hsel`  in  1  slave select from decoder.
- `haddr`  in  16  byte address; `haddr[13:2]` is the word index, `haddr[15:14]` is ignored (decoded upstream).
- `htrans`  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  0 byte, 1 halfword, 2 word; 3..7 unsupported.
- `hwdata`  in  32  write data, valid in data phase.
- `hready`  in  1  bus-wide ready (previous transfer complete).
- `hrdata`  out  32  read data.
- `hreadyout`  out  1  this slave's ready.
- `hresp`  out  1  0 OKAY, 1 ERROR.

## Operation

- Address phase accepted when `hsel & hready & htrans[1]` at a rising edge. On acceptance, latch word index, byte offset `haddr[1:0]`, `hsize` and `hwrite`.
- IDLE/BUSY with `hsel`, or any cycle without `hsel`: no access; next cycle is OKAY with zero wait.
- Error check at acceptance. An error is any of:
  - index ≥ `DEPTH`;
  - `hsize` > 2;
  - halfword with `haddr[0]`=1;
  - word with `haddr[1:0]`≠0.
- States:
  - IDLE: `hreadyout`=1, `hresp`=0.
  - WAIT: `hreadyout`=0, `hresp`=0, counter counts down from `WAIT_STATES`.
  - DATA: `hreadyout`=1, `hresp`=0, transfer completes.
  - ERR1: `hreadyout`=0, `hresp`=1.
  - ERR2: `hreadyout`=1, `hresp`=1.
- Transitions:
  - Valid transfer accepted: IDLE/DATA/ERR2 → WAIT if `WAIT_STATES`>0, else DATA.
  - WAIT → DATA when the counter reaches 1.
  - Erroneous transfer accepted → ERR1 → ERR2.
  - DATA/ERR2 with no new acceptance → IDLE.
  - A new address phase may be accepted in DATA and ERR2 (pipelined back-to-back).
- Writes:
  - Committed at the rising edge ending DATA, i.e. the edge where `hreadyout`=1 in the write data phase.
  - Byte lanes are little-endian. Byte writes lane `haddr[1:0]`; halfword writes lanes {1:0} or {3:2} by `haddr[1]`; word writes all lanes. Unselected lanes are preserved.
  - Errored writes never modify memory.
- Reads:
  - `hrdata` = full word `mem[latched index]` during DATA of a read; 0 in every other state.
  - Read data is not lane-masked.
- Read-after-write to the same word, back-to-back: the read returns the newly written value.
- Memory contents are not reset and are retained across `hresetn`. Content before the first write is undefined.

## Timing

- Reset values: `hreadyout`=1, `hresp`=0, `hrdata`=0, state IDLE, counter 0, latched controls 0.
- Asserting `hresetn` mid-transfer aborts it immediately (asynchronous). A write in WAIT is not committed.
- OKAY transfer latency:
  - address phase, then `WAIT_STATES` cycles with `hreadyout`=0, then one DATA cycle.
  - Total data phase is `WAIT_STATES`+1 cycles.
- ERROR response is always exactly 2 cycles, independent of `WAIT_STATES`.
- `hsel`/`htrans` changes while `hready`=0 (other slave stalling) are ignored.
- `hwdata` is sampled only on the commit edge. Earlier `hwdata` values in WAIT are don't-care.

## Test plan

- Reset, `WAIT_STATES`=0:
  - Stimulus: write word 0xDEADBEEF to 0x0008, then read 0x0008.
  - Response: write completes with zero wait; the read DATA cycle gives `hrdata`=0xDEADBEEF, `hresp`=0.
- Byte lanes:
  - Stimulus: write word 0x11223344 to 0x0040, then byte 0xAA to 0x0041, then halfword 0xBBCC to 0x0042, then read 0x0040.
  - Response: `hrdata`=0xBBCCAA44.
- `WAIT_STATES`=3:
  - Stimulus: write then read 0x0010.
  - Response: `hreadyout` is low for exactly 3 cycles each data phase; read data is valid only in the 4th cycle.
- Errors, `DEPTH`=256:
  - Stimulus: read 0x0400 (index 256), then word write 0x0012 (misaligned).
  - Response: each gives ERR1 (`hreadyout`=0, `hresp`=1) then ERR2 (`hreadyout`=1, `hresp`=1). The subsequent read of 0x0010 shows unchanged content.
- Pipelining:
  - Stimulus: NONSEQ write 0x00000055 to 0x0020 immediately followed by NONSEQ read 0x0020.
  - Response: the read returns 0x00000055 with no extra cycles. IDLE and BUSY with `hsel`=1 give OKAY, zero wait.
- Reset mid-operation, `WAIT_STATES`=3:
  - Stimulus: assert `hresetn` in the 2nd wait cycle of a write of 0xCAFE0000 to a word previously holding 0x12345678.
  - Response: outputs return to reset values asynchronously; a later read gives 0x12345678.
